// File: rtl/data_memory_pkg.sv
// Shared sizing for the data memory and its block gather logic.
// Derived widths follow from the word, block and depth values.
package data_memory_pkg;

  localparam int WORD_SIZE   = 32;
  localparam int BLOCK_SIZE  = 4;
  localparam int MEM_DEPTH   = 64;
  localparam int ADDR_BITS   = $clog2(MEM_DEPTH);
  localparam int OFFSET_BITS = $clog2(BLOCK_SIZE);

  // Clears the in-block offset bits, leaving the aligned block's first word index.
  function automatic logic [ADDR_BITS-1:0] block_base(input logic [ADDR_BITS-1:0] idx);
    logic [ADDR_BITS-1:0] mask;
    mask = '1;
    mask = mask << OFFSET_BITS;
    return idx & mask;
  endfunction

endpackage

// File: rtl/data_memory_block_gather.sv
// Combinational packer that collects the aligned block starting at base.
// Word k of the block lands at bits [k*WORD_SIZE +: WORD_SIZE].
module data_memory_block_gather
  import data_memory_pkg::*;
(
  input  logic [MEM_DEPTH*WORD_SIZE-1:0]  mem,
  input  logic [ADDR_BITS-1:0]            base,
  output logic [WORD_SIZE*BLOCK_SIZE-1:0] block
);

  logic [MEM_DEPTH-1:0][WORD_SIZE-1:0] words;

  assign words = mem;

  for (genvar k = 0; k < BLOCK_SIZE; k++) begin : g_word
    logic [ADDR_BITS-1:0] addr;
    assign addr = base + ADDR_BITS'(k);
    assign block[k*WORD_SIZE +: WORD_SIZE] = words[addr];
  end

endmodule

// File: rtl/data_memory.sv
// Flop-based word-addressed data memory with combinational word and block reads.
// Writes land on the rising edge; a synchronous active-low reset clears every word.
module data_memory
  import data_memory_pkg::*;
(
  input  logic [WORD_SIZE-1:0]            ptr,
  input  logic [WORD_SIZE-1:0]            val,
  output logic [WORD_SIZE-1:0]            out_data,
  output logic [WORD_SIZE*BLOCK_SIZE-1:0] out_block,
  input  logic                            clk,
  input  logic                            write_enable,
  input  logic                            rst_n
);

  logic [MEM_DEPTH-1:0][WORD_SIZE-1:0] mem;
  logic [ADDR_BITS-1:0]                index;
  logic [ADDR_BITS-1:0]                base;
  logic                                unused_ptr_high;

  // Upper address bits are dropped on purpose so accesses wrap modulo the depth.
  assign index           = ptr[ADDR_BITS-1:0];
  assign unused_ptr_high = ^ptr[WORD_SIZE-1:ADDR_BITS];
  assign base            = block_base(index);

  // Reset wins over a simultaneous write, and an unknown enable is never a write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (write_enable == 1'b1) begin
      mem[index] <= val;
    end
  end

  assign out_data = mem[index];

  data_memory_block_gather u_gather (
    .mem   (mem),
    .base  (base),
    .block (out_block)
  );

endmodule

// File: tb/tb_data_memory.sv
// Randomized self-checking bench for data_memory with an array-based reference model.
// Directed writes pin the model to hand-computed values before the random phase.
module tb_data_memory;
  import data_memory_pkg::*;

  logic [WORD_SIZE-1:0]            ptr;
  logic [WORD_SIZE-1:0]            val;
  logic [WORD_SIZE-1:0]            out_data;
  logic [WORD_SIZE*BLOCK_SIZE-1:0] out_block;
  logic                            clk;
  logic                            write_enable;
  logic                            rst_n;

  logic [WORD_SIZE-1:0] model_mem [MEM_DEPTH];
  bit                   model_valid;
  bit                   running;
  int                   total;
  int                   bad;

  data_memory dut (
    .ptr          (ptr),
    .val          (val),
    .out_data     (out_data),
    .out_block    (out_block),
    .clk          (clk),
    .write_enable (write_enable),
    .rst_n        (rst_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: an array updated from the write and reset rules at each rising edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) model_mem[i] = '0;
      model_valid = 1'b1;
    end else if (write_enable) begin
      model_mem[int'(ptr % MEM_DEPTH)] = val;
    end
  end

  function automatic logic [WORD_SIZE-1:0] model_word(input logic [WORD_SIZE-1:0] p);
    return model_mem[int'(p % MEM_DEPTH)];
  endfunction

  function automatic logic [WORD_SIZE*BLOCK_SIZE-1:0] model_block(input logic [WORD_SIZE-1:0] p);
    logic [WORD_SIZE*BLOCK_SIZE-1:0] blk;
    int first;
    first = (int'(p % MEM_DEPTH) / BLOCK_SIZE) * BLOCK_SIZE;
    for (int k = 0; k < BLOCK_SIZE; k++) blk[k*WORD_SIZE +: WORD_SIZE] = model_mem[first + k];
    return blk;
  endfunction

  task automatic check_output(input string name, input logic [WORD_SIZE*BLOCK_SIZE-1:0] actual,
                              input logic [WORD_SIZE*BLOCK_SIZE-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic we, input logic [WORD_SIZE-1:0] p,
                                input logic [WORD_SIZE-1:0] v);
    @(posedge clk);
    #1;
    rst_n        = r;
    write_enable = we;
    ptr          = p;
    val          = v;
  endtask

  // Every falling edge after the first reset, both outputs must match the model.
  always @(negedge clk) begin
    if (model_valid && running) begin
      check_output("model_data", {{(WORD_SIZE*(BLOCK_SIZE-1)){1'b0}}, out_data},
                   {{(WORD_SIZE*(BLOCK_SIZE-1)){1'b0}}, model_word(ptr)});
      check_output("model_block", out_block, model_block(ptr));
    end
  end

  initial begin
    total        = 0;
    bad          = 0;
    model_valid  = 1'b0;
    running      = 1'b1;
    rst_n        = 1'b0;
    write_enable = 1'b0;
    ptr          = 32'd3;
    val          = '0;

    apply_stimulus(1'b0, 1'b0, 32'd3, 32'd0);
    apply_stimulus(1'b1, 1'b0, 32'd3, 32'd0);
    #1;
    check_output("reset_data", {96'd0, out_data}, 128'd0);
    check_output("reset_block", out_block, 128'd0);

    apply_stimulus(1'b1, 1'b1, 32'd3, 32'd3);
    #1;
    check_output("pre_edge_data", {96'd0, out_data}, 128'd0);
    apply_stimulus(1'b1, 1'b0, 32'd3, 32'd0);
    #1;
    check_output("write3_data", {96'd0, out_data}, 128'd3);
    check_output("write3_block_hi", {96'd0, out_block[127:96]}, 128'd3);

    apply_stimulus(1'b1, 1'b1, 32'd3, 32'd8);
    apply_stimulus(1'b1, 1'b0, 32'd3, 32'd0);
    #1;
    check_output("rewrite_data", {96'd0, out_data}, 128'd8);
    apply_stimulus(1'b1, 1'b0, 32'd3, 32'd0);
    #1;
    check_output("hold_data", {96'd0, out_data}, 128'd8);

    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b1, 32'(4 + i), 32'(32'hA0 + i));
    apply_stimulus(1'b1, 1'b0, 32'd6, 32'd0);
    #1;
    check_output("block_4_7", out_block, 128'h000000A3_000000A2_000000A1_000000A0);
    check_output("word_6", {96'd0, out_data}, 128'hA2);

    apply_stimulus(1'b1, 1'b1, 32'(MEM_DEPTH + 2), 32'h55);
    apply_stimulus(1'b1, 1'b0, 32'd2, 32'd0);
    #1;
    check_output("wrap_data", {96'd0, out_data}, 128'h55);

    apply_stimulus(1'b1, 1'b1, 32'd9, 32'h11);
    apply_stimulus(1'b1, 1'b1, 32'd9, 32'h22);
    apply_stimulus(1'b1, 1'b0, 32'd9, 32'd0);
    #1;
    check_output("last_write_wins", {96'd0, out_data}, 128'h22);

    apply_stimulus(1'b0, 1'b1, 32'd3, 32'd7);
    apply_stimulus(1'b1, 1'b0, 32'd3, 32'd0);
    #1;
    check_output("reset_drops_write", {96'd0, out_data}, 128'd0);
    apply_stimulus(1'b1, 1'b0, 32'd6, 32'd0);
    #1;
    check_output("reset_clears_block", out_block, 128'd0);

    for (int n = 0; n < 600; n++) begin
      logic [WORD_SIZE-1:0] p;
      p = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 2 * MEM_DEPTH - 1));
      apply_stimulus(($urandom_range(0, 63) != 0), ($urandom_range(0, 1) == 1), p, $urandom());
    end
    apply_stimulus(1'b1, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    running = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory.md
# data_memory

Word-addressed data memory for the CPU's load/store path. Serves a single word for processor accesses and the whole aligned block containing that word for the cache refill path. Reads are combinational. Writes are single-word and synchronous. The array is cleared by reset.

## Interface
Parameters (shared values, see Structure):
- `WORD_SIZE`, 32: bits per word; also the width of `ptr`.
- `BLOCK_SIZE`, 4: words per block; must be a power of two ≥ 1.
- `MEM_DEPTH`, 64: number of words; must be a power of two and a multiple of `BLOCK_SIZE`.

Ports (positional order is `ptr`, `val`, `out_data`, `out_block`, `clk`, `write_enable`, `rst_n`):
- `clk`, input, 1: the single clock. All state changes on the rising edge.
- `rst_n`, input, 1: reset is synchronous and active-low.
- `ptr`, input, `WORD_SIZE`: word address (word index, not byte address).
- `val`, input, `WORD_SIZE`: write data.
- `out_data`, output, `WORD_SIZE`: the word at `ptr`.
- `out_block`, output, `WORD_SIZE*BLOCK_SIZE`: the aligned block containing `ptr`.
- `write_enable`, input, 1: when 1, writes `val` to `ptr` at the rising edge.

## Operation
- Storage is an array of `MEM_DEPTH` words of `WORD_SIZE` bits.
- Index decode: the word index is `ptr[log2(MEM_DEPTH)-1:0]`. Upper address bits are ignored, so addresses wrap modulo `MEM_DEPTH`. No error flag.
- `out_data` is `mem[index]`, driven combinationally.
- Block decode: the block base is `index` with its low `log2(BLOCK_SIZE)` bits cleared.
- `out_block` layout: word `k` of the block is `mem[base+k]` and sits at bits `[k*WORD_SIZE +: WORD_SIZE]`. Word 0 is in the LSBs.
- Write rule: at a rising edge with `rst_n`=1 and `write_enable`=1, `mem[index]` ← `val`. Only that word changes.
- Reset rule: at a rising edge with `rst_n`=0, every word is set to 0. Reset has priority over a simultaneous write, so the write is dropped.
- Reset values: both outputs read 0 everywhere after reset. They stay combinational during reset and show the array contents.
- Unknown or X on `write_enable` is treated as no write. The bench must never drive it.

## Timing
- Read latency is 0 cycles: `out_data` and `out_block` follow `ptr` combinationally.
- Write latency is 1 edge. Before the edge the outputs show the old value; after the edge they show `val`.
- Read during write at the same address returns the old data until the edge (no write-through bypass).
- Back-to-back writes to the same address: the last one wins, one per cycle.
- A write to any word in the block addressed by `ptr` updates `out_block` after the edge.
- Reset asserted in the middle of a sequence: contents are lost at the first edge where `rst_n`=0.

## Structure
- Shared package / `parameters.v` include holds `WORD_SIZE`, `BLOCK_SIZE`, `MEM_DEPTH`, and derived `ADDR_BITS` = log2(`MEM_DEPTH`) and `OFFSET_BITS` = log2(`BLOCK_SIZE`).
- One natural sub-module is `data_memory_block_gather`. It is combinational: it takes the array and the block base and emits the packed `out_block` (generate loop over `BLOCK_SIZE`).
- The array is flop-based rather than inferred RAM, because reset clears all words.

## Test plan
- Reset, then hold `ptr`=3, `write_enable`=0 → `out_data`=0 and `out_block`=0.
- `ptr`=3, `val`=3, `write_enable`=1 for one edge, then `write_enable`=0 → `out_data`=0x00000003 after the edge and 0 before it. `out_block` bits [127:96] = 3.
- Next, `ptr`=3, `val`=8, write → `out_data`=8. A following read cycle with `val`=0 and `write_enable`=0 still shows 8.
- Write 0xA0..0xA3 to addresses 4..7, then set `ptr`=6 → `out_block`=0x000000A3_000000A2_000000A1_000000A0 and `out_data`=0xA2.
- Wrap-around: write 0x55 to `ptr`=`MEM_DEPTH`+2, then read `ptr`=2 → 0x55.
- Assert `rst_n`=0 together with `write_enable`=1, `ptr`=3, `val`=7 → after the edge `mem[3]`=0 and all locations are 0.
